otter_line_arbiter: RTL and testbench
=====================================

# otter_line_arbiter

Parametrised N-channel line-transfer arbiter between the OTTER L1 caches and single-port main memory. It generalises the two-cache, one-adapter path of the current memory wrapper. Any number of cache controllers can request whole-line fills (read bursts) or writebacks (write bursts). The block serialises them onto one main-memory port using round-robin or fixed-priority arbitration, and walks the word index of each burst itself.

## Interface
- NUM_CH, default 2: number of requesting channels, 1..8.
- ADDR_W, default 32: byte-address width.
- WORD_W, default 32: data word width.
- WORDS_PER_LINE, default 8: burst length; must be a power of two, at least 2.
- ARB_MODE, default 0: 0 = round-robin; 1 = fixed priority, lowest channel index wins.

Ports:
- MEM_CLK  in  1  clock; all state updates on its rising edge.
- MEM_RST  in  1  reset; asynchronous and active-low. All state clears while it is low.
- REQ  in  NUM_CH  per-channel transfer request; held until that channel's DONE.
- WR  in  NUM_CH  per-channel direction; 1 = writeback, 0 = fill. Sampled at grant.
- ADDR  in  NUM_CH*ADDR_W  per-channel byte address. The low log2(WORDS_PER_LINE)+2 bits are ignored.
- WDATA  in  NUM_CH*WORD_W  per-channel write word for the current WORD_IDX; combinational from the requester.
- GNT  out  NUM_CH  one-hot grant; at most one bit set.
- WORD_IDX  out  log2(WORDS_PER_LINE)  index of the current word in the burst.
- RDATA  out  WORD_W  fill data; equals MM_DOUT.
- RVALID  out  NUM_CH  per-channel fill-word strobe.
- DONE  out  NUM_CH  one-cycle pulse on the channel whose burst completed.
- MM_RE  out  1  main-memory read enable.
- MM_WE  out  1  main-memory write enable.
- MM_ADDR  out  ADDR_W-2  main-memory word address.
- MM_DIN  out  WORD_W  main-memory write data.
- MM_DOUT  in  WORD_W  main-memory read data.
- MM_VALID  in  1  main-memory per-word acknowledge.

## Operation
- Internal FSM states: IDLE, XFER, FIN.
- Registers: grant index g, latched direction, latched line address, word counter, round-robin pointer rr.

IDLE:
- If any REQ bit is set, select a winner.
  - ARB_MODE 0: search from rr upward, modulo NUM_CH.
  - ARB_MODE 1: lowest index wins.
- On selection: latch g, WR[g] and ADDR[g] line bits; clear the word counter; go to XFER.

XFER:
- GNT[g] = 1.
- MM_ADDR = {latched line address, word counter}.
- Fill: MM_RE = 1, MM_WE = 0.
  - RVALID[g] = MM_VALID.
  - RDATA = MM_DOUT in every state.
- Writeback: MM_WE = 1, MM_RE = 0, MM_DIN = WDATA[g].
- On MM_VALID the word counter increments.
- On MM_VALID with counter = WORDS_PER_LINE-1: go to FIN.

FIN:
- DONE[g] = 1 and GNT[g] = 1 for exactly one cycle.
- MM_RE = MM_WE = 0.
- rr ← (g+1) mod NUM_CH; g = NUM_CH-1 wraps rr to 0.
- Next state IDLE.

Boundary rules:
- REQ[g] dropping during XFER is ignored: the burst completes and DONE still pulses.
- Changes to ADDR or WR after grant are ignored; the latched values are used.
- REQ on other channels during XFER/FIN waits and is arbitrated in the next IDLE cycle.
- Requester holding REQ through DONE: in round-robin mode, it may be re-granted only after the other pending channels. Worst-case wait is NUM_CH-1 bursts.
- NUM_CH = 1: the arbiter degenerates to a pass-through sequencer; rr stays 0.
- MM_VALID in IDLE or FIN is ignored, with no state change.
- MEM_RST asserted mid-burst: immediate abort. All outputs go to reset values asynchronously. No DONE is issued. The requester must re-request after reset.

Reset values: every output 0, including GNT, RVALID, DONE, MM_RE, MM_WE, MM_ADDR, MM_DIN and WORD_IDX. State = IDLE, rr = 0, g = 0, counter = 0.

## Timing
- Grant latency: REQ high in IDLE → GNT and MM_RE/MM_WE high on the next edge. Arbitration costs 1 cycle.
- Burst duration: WORDS_PER_LINE MM_VALID pulses, plus 1 FIN cycle, plus 1 IDLE cycle before the next grant.
- Fill data is combinational, zero added latency: RVALID[g] and RDATA are valid in the same cycle as MM_VALID.
- Write data: WDATA[g] is presented on MM_DIN in the same cycle WORD_IDX is shown. The requester sees the new index one cycle after each MM_VALID.
- MM_RE/MM_WE stay held high for the whole XFER state, including the main-memory delay cycles.
- Minimum spacing between back-to-back bursts: 2 cycles (FIN, IDLE).

## Test plan
- Single fill: NUM_CH=2; REQ[0]=1, WR=0, ADDR=0x6020; mock memory with a 10-cycle first-word delay, then 1 word/cycle returning 0xA0..0xA7. Required: MM_ADDR 0x1808..0x180F; RVALID[0] ×8 with matching RDATA; DONE[0] pulse; GNT returns to 0.
- Writeback: REQ[1]=1, WR=1, ADDR=0x7000; WDATA = 0xB0 + WORD_IDX. Required: MM_WE high; MM_DIN sequence 0xB0..0xB7; MM_RE stays 0; DONE[1] once.
- Round-robin contention: NUM_CH=4; REQ=4'b1111 held constantly. Required grant order 0,1,2,3,0. rr wraps from 3 to 0. No channel is granted twice before all others.
- Fixed priority: ARB_MODE=1; REQ=4'b1010 held. Required: channel 1 is granted repeatedly and channel 3 never while REQ[1] stays high.
- Requester drop: REQ[0] deasserted after word 3 of a fill. Required: the burst still completes all 8 words and DONE[0] pulses.
- Reset mid-burst: MEM_RST low after word 4. Required: GNT, MM_RE and RVALID drop to 0 without waiting for a clock edge; no DONE. After release, a new REQ[1] is granted with WORD_IDX starting at 0.

Source files
------------

// File: rtl/otter_line_arbiter.sv
// otter_line_arbiter: N-channel whole-line transfer arbiter in front of a
// single-port main memory. Each granted channel receives one burst of
// WORDS_PER_LINE words, either a fill (read) or a writeback (write). The
// arbiter generates the word index itself.
//
// Handshake: a channel raises REQ and holds it until it sees its DONE pulse.
// The memory acknowledges each word with a one-cycle MM_VALID. RE or WE is
// held high for the whole burst, and the word index advances on every
// MM_VALID. Fill data reaches the requester combinationally, marked by
// RVALID.
module otter_line_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int ARB_MODE       = 0
) (
    input  logic                               MEM_CLK,
    input  logic                               MEM_RST,
    input  logic [NUM_CH-1:0]                  REQ,
    input  logic [NUM_CH-1:0]                  WR,
    input  logic [NUM_CH*ADDR_W-1:0]           ADDR,
    input  logic [NUM_CH*WORD_W-1:0]           WDATA,
    output logic [NUM_CH-1:0]                  GNT,
    output logic [$clog2(WORDS_PER_LINE)-1:0]  WORD_IDX,
    output logic [WORD_W-1:0]                  RDATA,
    output logic [NUM_CH-1:0]                  RVALID,
    output logic [NUM_CH-1:0]                  DONE,
    output logic                               MM_RE,
    output logic                               MM_WE,
    output logic [ADDR_W-3:0]                  MM_ADDR,
    output logic [WORD_W-1:0]                  MM_DIN,
    input  logic [WORD_W-1:0]                  MM_DOUT,
    input  logic                               MM_VALID
);

    localparam int          IDX_W    = $clog2(WORDS_PER_LINE);
    localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          LINE_W   = ADDR_W - 2 - IDX_W;
    localparam int unsigned NUM_CH_U = NUM_CH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     g_q;
    logic [CH_W-1:0]     rr_q;
    logic                dir_q;
    logic [LINE_W-1:0]   line_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   gnt_q;
    logic [NUM_CH-1:0]   done_q;
    logic                re_q;
    logic                we_q;

    logic                win_found;
    logic [CH_W-1:0]     win_idx;
    logic [NUM_CH-1:0]   g_onehot;
    logic                xfer;
    logic                addr_low_unused;

    // The word-offset bits of each address are intentionally dropped.
    assign addr_low_unused = ^ADDR;

    // Returns the candidate channel for search slot 'off'. Round-robin starts
    // at the pointer and wraps. Fixed priority scans upward from channel 0.
    function automatic logic [CH_W-1:0] cand_idx(input logic [CH_W-1:0] ptr,
                                                 input int unsigned     off);
        int unsigned sum;
        if (ARB_MODE == 1) begin
            sum = off;
        end else begin
            sum = 32'(ptr) + off;
            if (sum >= NUM_CH_U) sum = sum - NUM_CH_U;
        end
        return sum[CH_W-1:0];
    endfunction

    // Winner selection: the first requesting channel in search order.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH_U; i++) begin
            if (!win_found && REQ[cand_idx(rr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = cand_idx(rr_q, i);
            end
        end
    end

    // One-hot form of the latched grant index.
    always_comb begin
        g_onehot        = '0;
        g_onehot[g_q]   = 1'b1;
    end

    // Main sequencer: arbitrate in IDLE, walk the burst in XFER, pulse DONE in FIN.
    always_ff @(posedge MEM_CLK or negedge MEM_RST) begin
        if (!MEM_RST) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            dir_q   <= 1'b0;
            line_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        g_q     <= win_idx;
                        dir_q   <= WR[win_idx];
                        line_q  <= ADDR[int'(win_idx)*ADDR_W + IDX_W + 2 +: LINE_W];
                        cnt_q   <= '0;
                        gnt_q   <= NUM_CH'(1) << win_idx;
                        re_q    <= ~WR[win_idx];
                        we_q    <= WR[win_idx];
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (MM_VALID) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            re_q    <= 1'b0;
                            we_q    <= 1'b0;
                            done_q  <= g_onehot;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    rr_q    <= (32'(g_q) == NUM_CH_U - 1) ? '0 : g_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign xfer     = (state_q == ST_XFER);
    assign GNT      = gnt_q;
    assign DONE     = done_q;
    assign MM_RE    = re_q;
    assign MM_WE    = we_q;
    assign WORD_IDX = cnt_q;
    assign RDATA    = MM_DOUT;
    assign RVALID   = (xfer && !dir_q && MM_VALID) ? g_onehot : '0;
    assign MM_ADDR  = xfer ? {line_q, cnt_q} : '0;
    assign MM_DIN   = (xfer && dir_q) ? WDATA[int'(g_q)*WORD_W +: WORD_W] : '0;

endmodule

// File: tb/tb_otter_line_arbiter.sv
// Bench for otter_line_arbiter. Two 4-channel instances share the request
// and memory stimulus: one uses round-robin arbitration, the other fixed
// priority. Bursts have a fixed length, so both instances advance in
// lockstep. Each instance is compared against its own expected grant,
// which comes from a behavioural arbitration model.
module tb_otter_line_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WPL = 8;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          req;
    logic [N-1:0]          wr;
    logic [N*AW-1:0]       addr;
    logic                  mm_valid;
    logic [DW-1:0]         mm_dout;

    logic [1:0][N*DW-1:0]  wdata_v;
    logic [1:0][N-1:0]     gnt_o, rvalid_o, done_o;
    logic [1:0][IW-1:0]    widx_o;
    logic [1:0][DW-1:0]    rdata_o, mm_din_o;
    logic [1:0]            mm_re_o, mm_we_o;
    logic [1:0][AW-3:0]    mm_addr_o;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    // Requester write data: channel tag in bits 23:16, 0xB0 + word index below.
    always_comb begin
        wdata_v = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++)
                wdata_v[d][c*DW +: DW] = (32'(c) << 16) | (32'hB0 + 32'(widx_o[d]));
    end

    otter_line_arbiter #(.NUM_CH(N), .ADDR_W(AW), .WORD_W(DW),
                         .WORDS_PER_LINE(WPL), .ARB_MODE(0)) u_rr (
        .MEM_CLK(clk), .MEM_RST(rst_n), .REQ(req), .WR(wr), .ADDR(addr),
        .WDATA(wdata_v[0]), .GNT(gnt_o[0]), .WORD_IDX(widx_o[0]),
        .RDATA(rdata_o[0]), .RVALID(rvalid_o[0]), .DONE(done_o[0]),
        .MM_RE(mm_re_o[0]), .MM_WE(mm_we_o[0]), .MM_ADDR(mm_addr_o[0]),
        .MM_DIN(mm_din_o[0]), .MM_DOUT(mm_dout), .MM_VALID(mm_valid)
    );

    otter_line_arbiter #(.NUM_CH(N), .ADDR_W(AW), .WORD_W(DW),
                         .WORDS_PER_LINE(WPL), .ARB_MODE(1)) u_fp (
        .MEM_CLK(clk), .MEM_RST(rst_n), .REQ(req), .WR(wr), .ADDR(addr),
        .WDATA(wdata_v[1]), .GNT(gnt_o[1]), .WORD_IDX(widx_o[1]),
        .RDATA(rdata_o[1]), .RVALID(rvalid_o[1]), .DONE(done_o[1]),
        .MM_RE(mm_re_o[1]), .MM_WE(mm_we_o[1]), .MM_ADDR(mm_addr_o[1]),
        .MM_DIN(mm_din_o[1]), .MM_DOUT(mm_dout), .MM_VALID(mm_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: round-robin searches upward from the pointer.
    function automatic int exp_rr(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Reference arbitration: the lowest requesting index wins.
    function automatic int exp_fp(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    // Word address = byte address with the line-offset bits replaced by the word number.
    function automatic logic [AW-3:0] exp_addr(input logic [31:0] a, input int k);
        logic [31:0] t;
        t = ((a >> 5) << 3) + 32'(k);
        return t[AW-3:0];
    endfunction

    task automatic set_ch(input int c, input logic w, input logic [31:0] a);
        wr[c] = w;
        addr[c*AW +: AW] = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_gnt"},    gnt_o[d],     0);
            chk({tag, "_rvalid"}, rvalid_o[d],  0);
            chk({tag, "_done"},   done_o[d],    0);
            chk({tag, "_re"},     mm_re_o[d],   0);
            chk({tag, "_we"},     mm_we_o[d],   0);
            chk({tag, "_addr"},   mm_addr_o[d], 0);
            chk({tag, "_din"},    mm_din_o[d],  0);
            chk({tag, "_widx"},   widx_o[d],    0);
        end
    endtask

    task automatic check_xfer(input int d, input int c, input logic w,
                              input logic [31:0] a, input int k);
        logic [N-1:0] oh;
        oh = N'(1) << c;
        chk("xfer_gnt",    gnt_o[d],     oh);
        chk("xfer_re",     mm_re_o[d],   !w);
        chk("xfer_we",     mm_we_o[d],   w);
        chk("xfer_widx",   widx_o[d],    k);
        chk("xfer_addr",   mm_addr_o[d], exp_addr(a, k));
        chk("xfer_rvalid", rvalid_o[d],  (mm_valid && !w) ? oh : '0);
        chk("xfer_rdata",  rdata_o[d],   mm_dout);
        chk("xfer_done",   done_o[d],    0);
        if (w) chk("xfer_din", mm_din_o[d], (32'(c) << 16) | (32'hB0 + 32'(k)));
    endtask

    // One complete burst on both instances. Entered at a negedge in IDLE
    // with REQ already driven; returns at the negedge of the IDLE cycle
    // after FIN.
    task automatic burst(input int first_delay, input bit scramble,
                         input int drop_ch, input int drop_word,
                         output int ch_rr, output int ch_fp);
        int          ch[2];
        logic        ewr[2];
        logic [31:0] ea[2];
        int          dly;
        ch[0] = exp_rr(req, rr_m);
        ch[1] = exp_fp(req);
        for (int d = 0; d < 2; d++) begin
            ewr[d] = wr[ch[d]];
            ea[d]  = addr[ch[d]*AW +: AW];
        end
        mm_valid = 1'($urandom_range(0, 1));
        #1;
        for (int d = 0; d < 2; d++) chk("idle_gnt", gnt_o[d], 0);
        @(posedge clk); @(negedge clk);
        if (scramble) begin
            wr   = N'($urandom);
            addr = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 0; k < WPL; k++) begin
            dly = (k == 0) ? first_delay : int'($urandom_range(0, 2));
            for (int j = 0; j <= dly; j++) begin
                mm_valid = (j == dly);
                mm_dout  = (j == dly) ? 32'hA0 + 32'(k) : $urandom;
                #1;
                for (int d = 0; d < 2; d++) check_xfer(d, ch[d], ewr[d], ea[d], k);
                if (j == dly && k == drop_word && drop_ch >= 0) req[drop_ch] = 1'b0;
                @(posedge clk); @(negedge clk);
            end
        end
        mm_valid = 1'($urandom_range(0, 1));
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("fin_done",   done_o[d],   N'(1) << ch[d]);
            chk("fin_gnt",    gnt_o[d],    N'(1) << ch[d]);
            chk("fin_re",     mm_re_o[d],  0);
            chk("fin_we",     mm_we_o[d],  0);
            chk("fin_rvalid", rvalid_o[d], 0);
        end
        rr_m = (ch[0] + 1) % N;
        @(posedge clk); @(negedge clk);
        mm_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("post_gnt",  gnt_o[d],  0);
            chk("post_done", done_o[d], 0);
        end
        ch_rr = ch[0];
        ch_fp = ch[1];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic [N-1:0] r;
        req = '0; wr = '0; addr = '0; mm_valid = 1'b0; mm_dout = '0;

        // Reset state
        @(negedge clk); #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        rr_m = 0;

        // Single fill, 10-cycle first-word delay, MM_ADDR 0x1808..0x180F
        set_ch(0, 1'b0, 32'h6020);
        req = 4'b0001;
        burst(10, 1'b0, -1, 0, c0, c1);
        req = '0;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) chk("fill_gnt_back_to_0", gnt_o[d], 0);

        // Writeback on channel 1
        set_ch(1, 1'b1, 32'h7000);
        req = 4'b0010;
        burst(3, 1'b0, -1, 0, c0, c1);
        req = '0;

        // Reset between tests so the round-robin pointer restarts at 0
        @(negedge clk);
        rst_n = 1'b0; #1;
        check_reset_outputs("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0;
        @(negedge clk);

        // Round-robin contention, all channels held, latched values used
        for (int c = 0; c < N; c++) set_ch(c, 1'($urandom_range(0, 1)), $urandom);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) burst(int'($urandom_range(0, 2)), 1'b1, -1, 0, c0, c1);

        // Fixed priority vs round-robin with channels 1 and 3 held
        for (int c = 0; c < N; c++) set_ch(c, 1'($urandom_range(0, 1)), $urandom);
        req = 4'b1010;
        for (int i = 0; i < 4; i++) burst(int'($urandom_range(0, 2)), 1'b0, -1, 0, c0, c1);

        // Randomized request patterns
        for (int i = 0; i < 12; i++) begin
            r = N'($urandom_range(1, 15));
            req = r;
            for (int c = 0; c < N; c++) set_ch(c, 1'($urandom_range(0, 1)), $urandom);
            burst(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 0, c0, c1);
        end

        // Requester drops REQ after word 3; burst still completes
        req = '0;
        set_ch(0, 1'b0, 32'h0000_4460);
        req = 4'b0001;
        burst(2, 1'b0, 0, 3, c0, c1);
        req = '0;

        // Reset mid-burst after word 4
        set_ch(2, 1'b0, 32'h0001_2340);
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            mm_valid = 1'b1;
            mm_dout  = 32'hA0 + 32'(k);
            @(posedge clk); @(negedge clk);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_widx", widx_o[d], 5);
            chk("mid_gnt",  gnt_o[d],  4'b0100);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        req = '0;
        mm_valid = 1'b0;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) chk("rst_hold_done", done_o[d], 0);
        rst_n = 1'b1;
        rr_m = 0;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_done", done_o[d], 0);
            chk("post_rst_gnt",  gnt_o[d],  0);
        end
        set_ch(1, 1'b0, 32'h0000_9A00);
        req = 4'b0010;
        burst(1, 1'b0, -1, 0, c0, c1);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
